// File: rtl/vector_lane_sequencer_if.sv
// Purpose: decode-side op handshake plus lane-side element group bus for the vector lane sequencer.
// Latency: pure wiring, no storage.
// Backpressure: start_valid/start_ready accept handshake; stall freezes the issued group, flush aborts the op.
// Ports: master = vector decode / downstream control side, slave = sequencer.
interface vector_lane_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int VL_W      = 8
);
    logic                      start_valid;
    logic                      start_ready;
    logic [VL_W-1:0]           vl;
    logic [VL_W-1:0]           vstart;
    logic                      serial;
    logic                      stall;
    logic                      flush;
    logic                      elem_valid;
    logic [NUM_LANES*VL_W-1:0] elem_idx;
    logic [NUM_LANES-1:0]      lane_active;
    logic                      first;
    logic                      last;
    logic                      done;
    logic                      busy;

    modport master (
        output start_valid, vl, vstart, serial, stall, flush,
        input  start_ready, elem_valid, elem_idx, lane_active, first, last, done, busy
    );

    modport slave (
        input  start_valid, vl, vstart, serial, stall, flush,
        output start_ready, elem_valid, elem_idx, lane_active, first, last, done, busy
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// Purpose: steps element indices of one accepted vector op, NUM_LANES per cycle (1 in serial mode).
// Latency: first group one cycle after accept; done pulse one cycle after the last group.
// Backpressure: stall holds the current group bit-for-bit; flush aborts to IDLE with no done pulse.
// Ports: CLK/RST (sync, active-high); bus (slave modport) carries the op handshake and element group outputs.
module vector_lane_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int VLEN      = 128,
    parameter int VL_W      = $clog2(VLEN) + 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    vector_lane_sequencer_if.slave  bus
);
    // One extra bit so base+step and base+lane never wrap in comparisons.
    localparam int SUM_W = VL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VL_W-1:0] base;
    logic [VL_W-1:0] vl_q;
    logic [VL_W-1:0] vstart_q;
    logic            serial_q;

    logic             accept;
    logic [SUM_W-1:0] step;
    logic [SUM_W-1:0] base_nxt;
    logic             last_grp;
    logic             in_run;

    // A flush in the same cycle as start_valid drops the request.
    assign accept   = (state == S_IDLE) && bus.start_valid && !bus.flush;
    assign step     = serial_q ? SUM_W'(1) : SUM_W'(NUM_LANES);
    assign base_nxt = {1'b0, base} + step;
    assign last_grp = (base_nxt >= {1'b0, vl_q});
    assign in_run   = (state == S_RUN);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        // Empty body (vl==0 or vstart past the end) retires without issuing.
                        state_nxt = (bus.vstart >= bus.vl) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.stall && last_grp) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Op registers and element base pointer
    always_ff @(posedge CLK) begin
        if (RST) begin
            base     <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            serial_q <= 1'b0;
        end else if (accept) begin
            base     <= bus.vstart;
            vl_q     <= bus.vl;
            vstart_q <= bus.vstart;
            serial_q <= bus.serial;
        end else if (in_run && !bus.stall && !bus.flush) begin
            base <= base_nxt[VL_W-1:0];
        end
    end

    // Output logic. Outputs depend only on registered state, so a stall
    // (which freezes every register) holds them unchanged.
    always_comb begin
        bus.start_ready = (state == S_IDLE) && !RST;
        bus.busy        = (state != S_IDLE);
        bus.done        = (state == S_DONE);
        bus.elem_valid  = in_run;
        bus.first       = in_run && (base == vstart_q);
        bus.last        = in_run && last_grp;
    end

    // Per-lane index and body flag; in serial mode only lane 0 carries an element.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [SUM_W-1:0] lane_sum;
        logic             lane_on;

        assign lane_sum = {1'b0, base} + SUM_W'(g);
        assign lane_on  = in_run && (!serial_q || (g == 0));
        assign bus.elem_idx[g*VL_W +: VL_W] = lane_on ? lane_sum[VL_W-1:0] : '0;
        assign bus.lane_active[g]           = lane_on && (lane_sum < {1'b0, vl_q});
    end
endmodule
